// File: rtl/level_decay_if.sv
// level_decay_if: sample, tick, coefficient and read bus for level_decay.
//   master: coef, tick, in_valid, in_ch, in_level, rd_ch  -> drives
//           rd_level, busy, pass_done, tick_miss          <- receives
//   slave:  the mirror image, used by the level_decay engine.
// CW defaults to clog2(CHANNELS). It may be set wider so that a driver can
// present channel indices beyond the last channel. The engine ignores writes
// to those indices and reads them back as 0.
interface level_decay_if #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 16,
    parameter int COEF_WIDTH = 8,
    parameter int CW         = $clog2(CHANNELS)
);
    logic [COEF_WIDTH-1:0] coef;
    logic                  tick;
    logic                  in_valid;
    logic [CW-1:0]         in_ch;
    logic [WIDTH-1:0]      in_level;
    logic [CW-1:0]         rd_ch;
    logic [WIDTH-1:0]      rd_level;
    logic                  busy;
    logic                  pass_done;
    logic                  tick_miss;

    modport master (
        output coef, tick, in_valid, in_ch, in_level, rd_ch,
        input  rd_level, busy, pass_done, tick_miss
    );

    modport slave (
        input  coef, tick, in_valid, in_ch, in_level, rd_ch,
        output rd_level, busy, pass_done, tick_miss
    );
endinterface

// File: rtl/level_decay.sv
// level_decay: multi-channel peak-hold and decay engine.
// Each channel keeps the maximum of the samples written to it. A tick starts
// one decay pass. The pass scales one channel per cycle by coef/2^COEF_WIDTH,
// using a single shared multiplier.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  level_decay_if.slave
//        coef/tick/in_valid/in_ch/in_level/rd_ch are inputs.
//        rd_level/busy/pass_done/tick_miss are registered outputs.
//
// state | meaning
// IDLE  | waiting for tick
// SCAN  | decaying channel scan_idx, one channel per cycle
// DONE  | one-cycle pass_done pulse, ticks here are misses
module level_decay #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 16,
    parameter int COEF_WIDTH = 8,
    parameter int CW         = $clog2(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst,
    level_decay_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                       state;
    logic [CW-1:0]                scan_idx;
    logic [WIDTH-1:0]             level_mem  [CHANNELS];
    logic [WIDTH-1:0]             level_next [CHANNELS];
    logic [WIDTH-1:0]             scan_level;
    logic [WIDTH-1:0]             rd_sel;
    logic [WIDTH+COEF_WIDTH-1:0]  product;
    logic [WIDTH-1:0]             decayed;

    // Channel selection uses compare loops rather than direct indexing.
    // This keeps out-of-range indices (possible when CW is wide) harmless.
    always_comb begin
        scan_level = '0;
        rd_sel     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (scan_idx == CW'(i))
                scan_level = level_mem[i];
            if (bus.rd_ch == CW'(i))
                rd_sel = level_mem[i];
        end
    end

    // Full-width product, then truncate. The result is never above the
    // original level, so no saturation is needed.
    assign product = {{COEF_WIDTH{1'b0}}, scan_level} * {{WIDTH{1'b0}}, bus.coef};
    assign decayed = WIDTH'(product >> COEF_WIDTH);

    // The decay is applied first and the sample max second. A sample that
    // lands on the channel being scanned therefore survives the decay.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            level_next[i] = level_mem[i];
            if (state == SCAN && scan_idx == CW'(i))
                level_next[i] = decayed;
            if (bus.in_valid && bus.in_ch == CW'(i) && bus.in_level > level_next[i])
                level_next[i] = bus.in_level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++)
                level_mem[i] <= '0;
            state         <= IDLE;
            scan_idx      <= '0;
            bus.rd_level  <= '0;
            bus.busy      <= 1'b0;
            bus.pass_done <= 1'b0;
            bus.tick_miss <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                level_mem[i] <= level_next[i];
            bus.rd_level  <= rd_sel;
            bus.pass_done <= 1'b0;
            bus.tick_miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tick) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                SCAN: begin
                    bus.tick_miss <= bus.tick;
                    if (scan_idx == CW'(CHANNELS - 1)) begin
                        state         <= DONE;
                        bus.busy      <= 1'b0;
                        bus.pass_done <= 1'b1;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                DONE: begin
                    bus.tick_miss <= bus.tick;
                    state         <= IDLE;
                    scan_idx      <= '0;
                end
                default: begin
                    state    <= IDLE;
                    scan_idx <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
